// File: rtl/rv_mem_arbiter.sv
// Two-requester (ifetch / load-store) arbiter for one shared memory bus.
// Optional watchdog with fake-ack recovery: define RV_ARB_TIMEOUT_EN.
module rv_mem_arbiter #(
  parameter int TIMEOUT_BITS = 8,
  parameter bit D_FIRST      = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_ibus_addr,
  input  logic        i_ibus_read,
  output logic [31:0] o_ibus_data,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_addr,
  input  logic        i_dbus_read,
  input  logic        i_dbus_write,
  input  logic [3:0]  i_dbus_write_sel,
  input  logic [31:0] i_dbus_write_data,
  output logic [31:0] o_dbus_data,
  output logic        o_dbus_ack,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_read,
  output logic        o_bus_write,
  output logic [3:0]  o_bus_write_sel,
  output logic [31:0] o_bus_write_data,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_ack,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state;
  logic   last_d;
  logic   i_req;
  logic   d_req;
  logic   pick_d;
  logic   gnt_i;
  logic   gnt_d;
  logic   tmo;
  logic   done;

  assign i_req  = i_ibus_read;
  assign d_req  = i_dbus_read | i_dbus_write;
  assign pick_d = d_req & (~i_req | ~last_d);
  assign gnt_i  = (state == GNT_I);
  assign gnt_d  = (state == GNT_D);

`ifdef RV_ARB_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] wd;

  always_ff @(posedge i_clk) begin
    if (i_reset || state == IDLE)
      wd <= '0;
    else
      wd <= wd + 1'b1;
  end

  assign tmo = (gnt_i | gnt_d) & (&wd) & ~i_bus_ack;
`else
  assign tmo = 1'b0;
`endif

  assign done = i_bus_ack | tmo;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      last_d <= ~D_FIRST;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req | d_req) begin
            state  <= pick_d ? GNT_D : GNT_I;
            last_d <= pick_d;
          end
        end
        GNT_I: if (!i_req || done) state <= IDLE;
        GNT_D: if (!d_req || done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Acks only reach a requester that still holds its request.
  always_comb begin
    o_bus_addr       = '0;
    o_bus_read       = 1'b0;
    o_bus_write      = 1'b0;
    o_bus_write_sel  = '0;
    o_bus_write_data = '0;
    o_ibus_data      = '0;
    o_ibus_ack       = 1'b0;
    o_dbus_data      = '0;
    o_dbus_ack       = 1'b0;
    o_timeout        = tmo & ~i_reset;
    unique case (1'b1)
      gnt_i: begin
        o_bus_addr      = i_ibus_addr;
        o_bus_read      = 1'b1;
        o_bus_write_sel = 4'b1111;
        o_ibus_data     = tmo ? 32'hDEAD_BEEF : i_bus_data;
        o_ibus_ack      = done & i_req & ~i_reset;
      end
      gnt_d: begin
        o_bus_addr       = i_dbus_addr;
        o_bus_read       = i_dbus_read & ~i_dbus_write;
        o_bus_write      = i_dbus_write;
        o_bus_write_sel  = i_dbus_write_sel;
        o_bus_write_data = i_dbus_write_data;
        o_dbus_data      = tmo ? 32'hDEAD_BEEF : i_bus_data;
        o_dbus_ack       = done & d_req & ~i_reset;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed testbench for rv_mem_arbiter.
// Timeout checks depend on RV_ARB_TIMEOUT_EN.
module tb_rv_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_ibus_addr;
  logic        i_ibus_read;
  logic [31:0] o_ibus_data;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_addr;
  logic        i_dbus_read;
  logic        i_dbus_write;
  logic [3:0]  i_dbus_write_sel;
  logic [31:0] i_dbus_write_data;
  logic [31:0] o_dbus_data;
  logic        o_dbus_ack;
  logic [31:0] o_bus_addr;
  logic        o_bus_read;
  logic        o_bus_write;
  logic [3:0]  o_bus_write_sel;
  logic [31:0] o_bus_write_data;
  logic [31:0] i_bus_data;
  logic        i_bus_ack;
  logic        o_timeout;

  int n_chk = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  rv_mem_arbiter #(
    .TIMEOUT_BITS(4),
    .D_FIRST(1'b1)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_ibus_addr(i_ibus_addr),
    .i_ibus_read(i_ibus_read),
    .o_ibus_data(o_ibus_data),
    .o_ibus_ack(o_ibus_ack),
    .i_dbus_addr(i_dbus_addr),
    .i_dbus_read(i_dbus_read),
    .i_dbus_write(i_dbus_write),
    .i_dbus_write_sel(i_dbus_write_sel),
    .i_dbus_write_data(i_dbus_write_data),
    .o_dbus_data(o_dbus_data),
    .o_dbus_ack(o_dbus_ack),
    .o_bus_addr(o_bus_addr),
    .o_bus_read(o_bus_read),
    .o_bus_write(o_bus_write),
    .o_bus_write_sel(o_bus_write_sel),
    .o_bus_write_data(o_bus_write_data),
    .i_bus_data(i_bus_data),
    .i_bus_ack(i_bus_ack),
    .o_timeout(o_timeout)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ibus_addr       = '0;
    i_ibus_read       = 1'b0;
    i_dbus_addr       = '0;
    i_dbus_read       = 1'b0;
    i_dbus_write      = 1'b0;
    i_dbus_write_sel  = '0;
    i_dbus_write_data = '0;
    i_bus_data        = '0;
    i_bus_ack         = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset = 1'b1;
    tick();
    tick();
    i_bus_data = 32'hFFFF_FFFF;
    #1;
    n_chk++;
    if ({o_bus_read, o_bus_write, o_ibus_ack, o_dbus_ack, o_timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 00000",
        {o_bus_read, o_bus_write, o_ibus_ack, o_dbus_ack, o_timeout});
    end
    n_chk++;
    if ({o_ibus_data, o_dbus_data} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h want 0 0", o_ibus_data, o_dbus_data);
    end
    i_reset = 1'b0;
    i_bus_data = '0;
  endtask

  task automatic test_fetch();
    apply_reset();
    i_ibus_addr = 32'h0000_0100;
    i_ibus_read = 1'b1;
    #1;
    n_chk++;
    if (o_bus_read !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_c0_read: got %b want 0", o_bus_read);
    end
    tick();
    n_chk++;
    if ({o_bus_read, o_bus_write, o_bus_write_sel, o_bus_addr, o_ibus_ack}
        !== {1'b1, 1'b0, 4'hF, 32'h0000_0100, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_c1_bus: got r=%b w=%b sel=%h a=%h ack=%b want 1 0 f 00000100 0",
        o_bus_read, o_bus_write, o_bus_write_sel, o_bus_addr, o_ibus_ack);
    end
    tick();
    i_bus_ack  = 1'b1;
    i_bus_data = 32'h1234_5678;
    #1;
    n_chk++;
    if ({o_ibus_ack, o_ibus_data} !== {1'b1, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL fetch_c2_ack: got %b %h want 1 12345678", o_ibus_ack, o_ibus_data);
    end
    n_chk++;
    if ({o_dbus_ack, o_dbus_data} !== 33'h0) begin
      n_fail++;
      $display("FAIL fetch_c2_dside: got %b %h want 0 0", o_dbus_ack, o_dbus_data);
    end
    tick();
    i_bus_ack   = 1'b0;
    i_ibus_read = 1'b0;
    #1;
    n_chk++;
    if ({o_bus_read, o_ibus_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_c3_idle: got %b want 00", {o_bus_read, o_ibus_ack});
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    i_ibus_addr = 32'h0000_0100;
    i_ibus_read = 1'b1;
    i_dbus_addr = 32'h2000_0000;
    i_dbus_read = 1'b1;
    // Three ties in a row: d, i, d
    for (int t = 0; t < 3; t++) begin
      tick();
      #1;
      n_chk++;
      if (o_bus_addr !== ((t == 1) ? 32'h0000_0100 : 32'h2000_0000)) begin
        n_fail++;
        $display("FAIL tie%0d_addr: got %h", t, o_bus_addr);
      end
      tick();
      i_bus_ack  = 1'b1;
      i_bus_data = 32'hC0DE_0000 + t;
      #1;
      n_chk++;
      if ({o_ibus_ack, o_dbus_ack} !== ((t == 1) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL tie%0d_acks: got i=%b d=%b", t, o_ibus_ack, o_dbus_ack);
      end
      n_chk++;
      if ((o_ibus_data | o_dbus_data) !== 32'hC0DE_0000 + t) begin
        n_fail++;
        $display("FAIL tie%0d_data: got %h %h want %h", t, o_ibus_data, o_dbus_data,
          32'hC0DE_0000 + t);
      end
      tick();
      i_bus_ack = 1'b0;
      #1;
      n_chk++;
      if (o_bus_read !== 1'b0) begin
        n_fail++;
        $display("FAIL tie%0d_gap: got read=%b want 0", t, o_bus_read);
      end
    end
    clear_inputs();
  endtask

  task automatic test_store();
    apply_reset();
    i_dbus_addr       = 32'h2000_0040;
    i_dbus_read       = 1'b1;
    i_dbus_write      = 1'b1;
    i_dbus_write_sel  = 4'b0011;
    i_dbus_write_data = 32'hAABB_CCDD;
    tick();
    n_chk++;
    if ({o_bus_write, o_bus_read, o_bus_write_sel, o_bus_write_data, o_bus_addr}
        !== {1'b1, 1'b0, 4'b0011, 32'hAABB_CCDD, 32'h2000_0040}) begin
      n_fail++;
      $display("FAIL store_bus: got w=%b r=%b sel=%b d=%h a=%h",
        o_bus_write, o_bus_read, o_bus_write_sel, o_bus_write_data, o_bus_addr);
    end
    n_chk++;
    if (o_dbus_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL store_early_ack: got %b want 0", o_dbus_ack);
    end
    tick();
    i_bus_ack = 1'b1;
    #1;
    n_chk++;
    if ({o_dbus_ack, o_ibus_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL store_ack: got d=%b i=%b want 1 0", o_dbus_ack, o_ibus_ack);
    end
    tick();
    clear_inputs();
    #1;
    n_chk++;
    if ({o_bus_write, o_bus_read} !== 2'b00) begin
      n_fail++;
      $display("FAIL store_idle: got %b want 00", {o_bus_write, o_bus_read});
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_dbus_addr = 32'h2000_0080;
    i_dbus_read = 1'b1;
    tick();
    n_chk++;
    if (o_bus_read !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_grant: got %b want 1", o_bus_read);
    end
    tick();
    i_reset   = 1'b1;
    i_bus_ack = 1'b1;
    #1;
    n_chk++;
    if (o_dbus_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_ack_in_reset: got %b want 0", o_dbus_ack);
    end
    tick();
    i_reset     = 1'b0;
    i_bus_ack   = 1'b0;
    i_dbus_read = 1'b0;
    i_ibus_addr = 32'h0000_0200;
    i_ibus_read = 1'b1;
    #1;
    n_chk++;
    if ({o_bus_read, o_bus_write, o_dbus_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_after: got %b want 000", {o_bus_read, o_bus_write, o_dbus_ack});
    end
    tick();
    n_chk++;
    if ({o_bus_read, o_bus_addr} !== {1'b1, 32'h0000_0200}) begin
      n_fail++;
      $display("FAIL rstmid_fetch: got %b %h want 1 00000200", o_bus_read, o_bus_addr);
    end
    tick();
    i_bus_ack  = 1'b1;
    i_bus_data = 32'h0BAD_F00D;
    #1;
    n_chk++;
    if ({o_ibus_ack, o_ibus_data} !== {1'b1, 32'h0BAD_F00D}) begin
      n_fail++;
      $display("FAIL rstmid_fetch_ack: got %b %h want 1 0badf00d", o_ibus_ack, o_ibus_data);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    i_ibus_addr = 32'h0000_0300;
    i_ibus_read = 1'b1;
`ifdef RV_ARB_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_chk++;
      if ({o_bus_read, o_ibus_ack, o_timeout} !== 3'b100) begin
        n_fail++;
        $display("FAIL tmo_wait%0d: got %b want 100", k, {o_bus_read, o_ibus_ack, o_timeout});
      end
    end
    tick();
    n_chk++;
    if ({o_ibus_ack, o_ibus_data, o_timeout} !== {1'b1, 32'hDEAD_BEEF, 1'b1}) begin
      n_fail++;
      $display("FAIL tmo_fire: got %b %h %b want 1 deadbeef 1", o_ibus_ack, o_ibus_data,
        o_timeout);
    end
    tick();
    i_ibus_read = 1'b0;
    #1;
    n_chk++;
    if ({o_bus_read, o_ibus_ack, o_timeout} !== 3'b000) begin
      n_fail++;
      $display("FAIL tmo_idle: got %b want 000", {o_bus_read, o_ibus_ack, o_timeout});
    end
`else
    repeat (100) tick();
    n_chk++;
    if ({o_bus_read, o_ibus_ack, o_timeout} !== 3'b100) begin
      n_fail++;
      $display("FAIL notmo_hold: got %b want 100", {o_bus_read, o_ibus_ack, o_timeout});
    end
`endif
    clear_inputs();
    apply_reset();
  endtask

  task automatic test_idle_ack();
    apply_reset();
    i_bus_ack  = 1'b1;
    i_bus_data = 32'h5555_AAAA;
    #1;
    n_chk++;
    if ({o_ibus_ack, o_dbus_ack, o_ibus_data, o_dbus_data} !== 66'h0) begin
      n_fail++;
      $display("FAIL idle_ack: got %b %b %h %h want 0", o_ibus_ack, o_dbus_ack,
        o_ibus_data, o_dbus_data);
    end
    tick();
    i_bus_ack = 1'b0;
    #1;
    n_chk++;
    if ({o_bus_read, o_bus_write, o_ibus_ack, o_dbus_ack} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_stay: got %b want 0000",
        {o_bus_read, o_bus_write, o_ibus_ack, o_dbus_ack});
    end
  endtask

  initial begin
    clear_inputs();
    i_reset = 1'b1;
    test_reset();
    test_fetch();
    test_back_to_back();
    test_store();
    test_reset_mid();
    test_timeout();
    test_idle_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Two-requester arbiter with a sequencing state machine. It shares one cacheable memory/slave bus between the instruction-fetch path and the data load/store path.
- Sits between the core's two bus masters and the single bus port feeding the cache/bus slaves.
- Holds each grant until the slave acks, so the bus carries at most one transaction at a time.
- Routes returned data and ack only to the owning requester.

Parameters:
- TIMEOUT_BITS, 8, width of the watchdog counter. Timeout fires after 2**TIMEOUT_BITS-1 cycles without ack.
- D_FIRST, 1, which requester wins the first tie after reset: 1 = data port, 0 = instruction port.

Ports:
- i_clk  input  1  clock; all logic on the rising edge
- i_reset  input  1  synchronous reset, active-high
- i_ibus_addr  input  32  instruction fetch address
- i_ibus_read  input  1  fetch request; level, held until o_ibus_ack
- o_ibus_data  output  32  fetch read data; valid when o_ibus_ack=1
- o_ibus_ack  output  1  fetch transaction complete
- i_dbus_addr  input  32  load/store address
- i_dbus_read  input  1  load request; level, held until o_dbus_ack
- i_dbus_write  input  1  store request; level, held until o_dbus_ack
- i_dbus_write_sel  input  4  store byte enables
- i_dbus_write_data  input  32  store data
- o_dbus_data  output  32  load data; valid when o_dbus_ack=1
- o_dbus_ack  output  1  load/store complete
- o_bus_addr  output  32  shared bus address
- o_bus_read  output  1  shared bus read strobe
- o_bus_write  output  1  shared bus write strobe
- o_bus_write_sel  output  4  shared bus byte enables
- o_bus_write_data  output  32  shared bus write data
- i_bus_data  input  32  shared bus read data
- i_bus_ack  input  1  shared bus ack
- o_timeout  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (i_reset=1 at an edge):
  - state=IDLE; round-robin pointer set per D_FIRST; watchdog=0.
  - All bus strobes, acks and o_timeout are 0.
  - Data outputs are 0 while idle.
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - Samples requests. Only ibus -> GNT_I. Only dbus (read or write) -> GNT_D.
  - Both requesting -> the side not granted last; first tie after reset per D_FIRST.
  - Neither -> stay IDLE.
  - Pointer updates on every grant.
- GNT_I:
  - o_bus_addr=i_ibus_addr, o_bus_read=1, o_bus_write=0, o_bus_write_sel=4'b1111, write data=0.
  - o_ibus_data=i_bus_data and o_ibus_ack=i_bus_ack, both combinational.
  - On i_bus_ack -> IDLE.
- GNT_D:
  - Address and write fields come from the dbus.
  - i_dbus_write=1 forces o_bus_read=0 even if i_dbus_read is also high; a write has priority.
  - Otherwise o_bus_read=i_dbus_read.
  - o_dbus_ack=i_bus_ack; on ack -> IDLE.
- Non-granted side: ack=0 and data=0 at all times.
- Latency:
  - Request seen in IDLE -> bus strobe next cycle.
  - Ack cycle -> IDLE on the following cycle.
  - Minimum 3 cycles per transaction with a zero-wait slave. Back-to-back transactions are separated by exactly one IDLE cycle.
- Requester drop:
  - If the granted requester deasserts its request before ack (illegal but tolerated), the arbiter returns to IDLE next cycle.
  - No ack is forwarded in that case.
- Ack while IDLE: i_bus_ack is ignored; no requester ack.
- Reset mid-transaction: abandons the grant immediately; no ack is delivered.
- Watchdog:
  - Counts cycles in GNT_I/GNT_D; cleared on entry to IDLE.
  - Only active with the optional feature.

Optional Feature:
- Macro: RV_ARB_TIMEOUT_EN.
- Defined:
  - When the watchdog reaches 2**TIMEOUT_BITS-1 with no ack, the arbiter fakes the ack: the granted requester's ack=1 with data 32'hDEADBEEF, o_timeout=1 for that cycle, then -> IDLE.
  - All bus strobes drop the next cycle.
- Undefined: counter not built; o_timeout tied 0; a grant waits for ack indefinitely.

Test Plan:
- Fetch only: i_ibus_read=1, addr 0x0000_0100; slave acks with 0x1234_5678 one cycle after the strobe -> o_bus_read from cycle 1, o_ibus_ack=1 with data 0x1234_5678 in cycle 2, o_dbus_ack=0 throughout, IDLE in cycle 3.
- Simultaneous requests after reset with D_FIRST=1; ibus 0x100, dbus read 0x2000_0000 -> dbus served first. Next tie goes to ibus. A third tie goes to dbus (alternation).
- Store with i_dbus_read=1 and i_dbus_write=1, sel 4'b0011, data 0xAABB_CCDD -> o_bus_write=1, o_bus_read=0, o_bus_write_sel=0011, data passed through, o_dbus_ack on i_bus_ack.
- i_reset asserted in GNT_D before ack -> next cycle all strobes=0, no ack; a subsequent fetch is granted normally.
- RV_ARB_TIMEOUT_EN, TIMEOUT_BITS=4, slave never acks a fetch -> after 15 granted cycles o_ibus_ack=1, o_ibus_data=0xDEADBEEF and o_timeout=1 for one cycle, then IDLE. Without the macro, the strobe is still held at cycle 100.
- i_bus_ack pulsed while IDLE with no requests -> no requester ack, state stays IDLE.
